// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial packed-BCD adder/subtractor.
// One BCD digit per clock, least-significant digit first, through one shared
// decimal-adjust stage. Operands are taken on start&&ready, and the result is
// flagged by a one-cycle valid pulse NDIG cycles after the accept edge.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request, accepted only when ready=1
//   sub               0: a+b+cin, 1: a-b-cin (cin is the borrow-in)
//   cin               carry-in / borrow-in
//   a, b              packed BCD operands, digit i at [4i+3:4i]
//   ready             idle, the next start is accepted
//   valid             one-cycle pulse, sum/cout/err are final
//   sum               packed BCD result (10's complement on a sub borrow)
//   cout              add: decimal carry-out, sub: borrow
//   err               a or b held a non-BCD digit when accepted

// Shared single-digit decimal add with adjust. t is at most 15+15+1=31, so
// 5 bits cover every input, including non-BCD digits.
module bcd_dig_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co
);
  logic [4:0] t, t6;
  assign t  = {1'b0, a} + {1'b0, b} + {4'b0, ci};
  assign t6 = t + 5'd6;
  assign co = (t > 5'd9);
  assign d  = co ? t6[3:0] : t[3:0];
endmodule

module bcd_addsub_serial #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic              cin,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              ready,
  output logic              valid,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);
  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q, b_q, res;
  logic [CW-1:0]   cnt;
  logic            c, sub_q;

  // Per-digit operand prep: b or its 9's complement, plus the non-BCD flag.
  logic [NDIG-1:0][3:0] bnc;
  logic [NDIG-1:0]      bad;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign bnc[g] = sub ? (4'd9 - b[4*g +: 4]) : b[4*g +: 4];
    assign bad[g] = (a[4*g +: 4] > 4'd9) || (b[4*g +: 4] > 4'd9);
  end

  // Operands shift right one digit per cycle, so the adjust stage always sees
  // digit 0 of the shift registers; results enter the top of res and land in
  // their final positions after NDIG shifts.
  logic [3:0]   dd;
  logic         dco;
  logic [W-1:0] res_nxt;

  bcd_dig_add u_adj (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (c),
    .d  (dd),
    .co (dco)
  );

  if (NDIG == 1) begin : g_res1
    assign res_nxt = dd;
  end else begin : g_resn
    assign res_nxt = {dd, res[W-1:4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      c     <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && ready) begin
            a_q   <= a;
            b_q   <= bnc;
            // Subtraction is a + 9's-comp(b) + 1 - borrow_in.
            c     <= sub ? ~cin : cin;
            sub_q <= sub;
            err   <= |bad;
            res   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          c   <= dco;
          res <= res_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_nxt;
            // In complement subtraction a final carry means no borrow.
            cout  <= sub_q ? ~dco : dco;
            valid <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_addsub_serial.sv
module tb_bcd_addsub_serial;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, cin;
  logic [W-1:0] a, b, sum;
  logic         ready, valid, cout, err;

  int checks   = 0;
  int failures = 0;

  bcd_addsub_serial #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .ready (ready),
    .valid (valid),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values.
  function automatic longint pow10();
    longint r = 1;
    for (int i = 0; i < NDIG; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit r = 0;
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) r = 1;
    return r;
  endfunction

  // Runs one operation from a negedge; returns at the negedge after valid+1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic tc, input bit chk_res);
    longint m, r;
    logic [W-1:0] es;
    logic ec, ee;
    int lat;
    bit rdy_bad;
    m  = pow10();
    ee = has_bad(ta) || has_bad(tb_);
    if (!ts) begin
      r  = bcd2int(ta) + bcd2int(tb_) + longint'(tc);
      ec = (r >= m);
      es = int2bcd(r % m);
    end else begin
      r  = bcd2int(ta) - bcd2int(tb_) - longint'(tc);
      ec = (r < 0);
      if (r < 0) r = r + m;
      es = int2bcd(r);
    end
    lat = 0;
    while (!ready && lat < 20) begin @(negedge clk); lat++; end
    check("ready_wait", ready, 1);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = 0;
    rdy_bad = ready;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready) rdy_bad = 1;
    end
    check("latency", lat, NDIG);
    check("ready_low", rdy_bad, 0);
    check("err", err, ee);
    if (chk_res) begin
      check("sum", sum, es);
      check("cout", cout, ec);
    end
    @(negedge clk);
    check("valid_pulse", valid, 0);
    check("ready_back", ready, 1);
  endtask

  initial begin
    int t, last, gaps_bad, npulse, bad_vld;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(16'h1234, 16'h8766, 1'b0, 1'b0, 1);
    run_op(16'h9999, 16'h0000, 1'b0, 1'b1, 1);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 1);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b0, 1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1);
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
    // Outputs hold while idle
    repeat (3) @(negedge clk);
    check("hold_sum", sum, 16'h0002);
    check("hold_err", err, 0);

    // start held high: one op every NDIG+2 cycles, single-cycle valid
    a = 16'h0123; b = 16'h0456; sub = 1'b0; cin = 1'b0; start = 1'b1;
    last = -1; gaps_bad = 0; npulse = 0; bad_vld = 0;
    for (t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (valid) begin
        if (last >= 0 && t - last != NDIG + 2) gaps_bad++;
        if (ready || sum !== 16'h0579) bad_vld++;
        last = t;
        npulse++;
      end
    end
    start = 1'b0;
    check("hs_gap", gaps_bad, 0);
    check("hs_pulses", npulse >= 6, 1);
    check("hs_valid_state", bad_vld, 0);
    repeat (NDIG + 3) @(negedge clk);

    // Reset mid-RUN after two digits
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;
    bad_vld = 0;
    repeat (8) begin @(negedge clk); if (valid) bad_vld++; end
    check("mid_rst_novalid", bad_vld, 0);
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, 1);
    check("after_rst_sum", sum, 16'h0010);
    check("after_rst_cout", cout, 0);

    // Random operations, occasionally with a non-BCD digit
    for (int n = 0; n < 60; n++) begin
      bit inj;
      for (int i = 0; i < NDIG; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      inj = ($urandom_range(0, 7) == 0);
      if (inj) begin
        int d;
        d = $urandom_range(0, NDIG - 1);
        if ($urandom_range(0, 1) == 0) ra[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*d +: 4] = 4'($urandom_range(10, 15));
      end
      run_op(ra, rb, 1'($urandom), 1'($urandom), !inj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
